// File: rtl/uart_parity_engine.sv
// -----------------------------------------------------------------------------
// uart_parity_engine
//
// Serial parity generator/checker for the UART datapath. Data bits are
// XOR-accumulated one at a time (LSB first) as they shift through the TX or
// RX frame logic. Once DATA_W bits have arrived, the generated parity bit is
// presented on par_out with par_ready. A received parity bit (par_valid/par_in)
// is then compared against it, producing a one-cycle chk_valid pulse and, on
// mismatch, a par_err pulse. Protocol violations pulse seq_err.
//
// Optional feature macro: UART_PAR_ERRCNT_EN
//   defined   -> saturating parity-error counter on err_cnt, cleared by err_clr
//   undefined -> err_cnt tied to 0, err_clr ignored
//
// Parameters:
//   DATA_W     data bits per frame (1..16)
//   ERR_CNT_W  width of the parity-error counter
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   parity_mode  00 even, 01 odd, 10 mark, 11 space; sampled on frame_start
//   frame_start  one-cycle pulse, begins a new frame
//   bit_valid    bit_in carries the next data bit
//   bit_in       data bit
//   par_valid    par_in carries the received parity bit
//   par_in       received parity bit
//   err_clr      clear the error counter
//   busy         frame in progress (accumulating or waiting for parity)
//   par_ready    all data bits received; par_out valid
//   par_out      generated parity bit for the current frame
//   chk_valid    one-cycle pulse, parity check completed
//   par_err      one-cycle pulse with chk_valid on mismatch
//   seq_err      one-cycle pulse on protocol violation
//   err_cnt      saturating parity-error count
// -----------------------------------------------------------------------------
module uart_parity_engine #(
    parameter int DATA_W    = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           parity_mode,
    input  logic                 frame_start,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic                 par_valid,
    input  logic                 par_in,
    input  logic                 err_clr,
    output logic                 busy,
    output logic                 par_ready,
    output logic                 par_out,
    output logic                 chk_valid,
    output logic                 par_err,
    output logic                 seq_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ACCUM    = 2'b01,
        ST_WAIT_PAR = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_mode_e;

    state_e           state_q, state_d;
    par_mode_e        mode_q, mode_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic busy_q, busy_d;
    logic par_ready_q, par_ready_d;
    logic par_out_q, par_out_d;
    logic chk_valid_q, chk_valid_d;
    logic par_err_q, par_err_d;
    logic seq_err_q, seq_err_d;

    function automatic logic parity_of(input par_mode_e mode, input logic acc);
        case (mode)
            PAR_EVEN:  return acc;
            PAR_ODD:   return ~acc;
            PAR_MARK:  return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

    // Next-state and next-output logic.
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default would infer a latch.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        chk_valid_d = 1'b0;
        par_err_d   = 1'b0;
        seq_err_d   = 1'b0;

        if (frame_start) begin
            // A new frame always wins: any frame in flight is aborted without a
            // check, and a coincident bit_valid is dropped silently. A
            // coincident par_valid can never be processed, so it is flagged.
            seq_err_d = (state_q != ST_IDLE) || par_valid;
            state_d   = ST_ACCUM;
            mode_d    = par_mode_e'(parity_mode);
            acc_d     = 1'b0;
            cnt_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    seq_err_d = bit_valid || par_valid;
                end
                ST_ACCUM: begin
                    seq_err_d = par_valid;
                    if (bit_valid) begin
                        acc_d = acc_q ^ bit_in;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            state_d = ST_WAIT_PAR;
                        end
                    end
                end
                ST_WAIT_PAR: begin
                    seq_err_d = bit_valid;
                    if (par_valid) begin
                        chk_valid_d = 1'b1;
                        par_err_d   = (par_in != par_out_q);
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d      = (state_d != ST_IDLE);
        par_ready_d = (state_d == ST_WAIT_PAR);
        // par_out is only meaningful while par_ready is high; tracking it every
        // cycle keeps it registered and already settled when WAIT_PAR begins.
        par_out_d   = parity_of(mode_d, acc_d);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= PAR_EVEN;
            acc_q       <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            par_ready_q <= 1'b0;
            par_out_q   <= 1'b0;
            chk_valid_q <= 1'b0;
            par_err_q   <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            par_ready_q <= par_ready_d;
            par_out_q   <= par_out_d;
            chk_valid_q <= chk_valid_d;
            par_err_q   <= par_err_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign busy      = busy_q;
    assign par_ready = par_ready_q;
    assign par_out   = par_out_q;
    assign chk_valid = chk_valid_q;
    assign par_err   = par_err_q;
    assign seq_err   = seq_err_q;

`ifdef UART_PAR_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // A clear coincident with a new error leaves that error counted.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = par_err_d ? ERR_CNT_W'(1) : '0;
        end else if (par_err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_uart_parity_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_parity_engine
//
// Self-checking bench for uart_parity_engine. DUT "a" (DATA_W=8, ERR_CNT_W=2)
// runs directed frames followed by randomized traffic, compared every cycle
// against a queue-based frame model. DUT "b" (DATA_W=5) covers the short-frame
// case and reset while waiting for parity. Honors UART_PAR_ERRCNT_EN.
// -----------------------------------------------------------------------------
module tb_uart_parity_engine;

    localparam int A_DATA_W = 8;
    localparam int A_ERR_W  = 2;
    localparam int A_ERR_MAX = (1 << A_ERR_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT a signals
    logic       rst, frame_start, bit_valid, bit_in, par_valid, par_in, err_clr;
    logic [1:0] parity_mode;
    logic       busy, par_ready, par_out, chk_valid, par_err, seq_err;
    logic [A_ERR_W-1:0] err_cnt;

    // DUT b signals
    logic       b_rst, b_frame_start, b_bit_valid, b_bit_in, b_par_valid, b_par_in, b_err_clr;
    logic [1:0] b_parity_mode;
    logic       b_busy, b_par_ready, b_par_out, b_chk_valid, b_par_err, b_seq_err;
    logic [7:0] b_err_cnt;

    uart_parity_engine #(.DATA_W(A_DATA_W), .ERR_CNT_W(A_ERR_W)) dut_a (
        .clk(clk), .rst(rst), .parity_mode(parity_mode), .frame_start(frame_start),
        .bit_valid(bit_valid), .bit_in(bit_in), .par_valid(par_valid), .par_in(par_in),
        .err_clr(err_clr), .busy(busy), .par_ready(par_ready), .par_out(par_out),
        .chk_valid(chk_valid), .par_err(par_err), .seq_err(seq_err), .err_cnt(err_cnt)
    );

    uart_parity_engine #(.DATA_W(5), .ERR_CNT_W(8)) dut_b (
        .clk(clk), .rst(b_rst), .parity_mode(b_parity_mode), .frame_start(b_frame_start),
        .bit_valid(b_bit_valid), .bit_in(b_bit_in), .par_valid(b_par_valid), .par_in(b_par_in),
        .err_clr(b_err_clr), .busy(b_busy), .par_ready(b_par_ready), .par_out(b_par_out),
        .chk_valid(b_chk_valid), .par_err(b_par_err), .seq_err(b_seq_err), .err_cnt(b_err_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model for DUT a ----------------
    // A frame is "active" from frame_start until its parity is checked; the
    // collected data bits live in a queue, and the frame waits for parity once
    // the queue holds A_DATA_W bits.
    bit        m_active;
    logic      m_bits[$];
    logic [1:0] m_mode;
    int        m_cnt;
    logic      e_chk, e_perr, e_seq;

    function automatic logic model_par();
        int ones = 0;
        foreach (m_bits[i]) ones += int'(m_bits[i]);
        case (m_mode)
            2'b00:   return logic'(ones % 2);
            2'b01:   return logic'((ones + 1) % 2);
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_waiting();
        return m_active && (m_bits.size() == A_DATA_W);
    endfunction

    task automatic model_cycle(input logic fs, input logic [1:0] m, input logic bv,
                               input logic bi, input logic pv, input logic pi,
                               input logic clr);
        bit err = 0;
        e_chk = 0; e_perr = 0; e_seq = 0;
        if (fs) begin
            e_seq    = m_active || pv;
            m_active = 1;
            m_bits.delete();
            m_mode   = m;
        end else if (!m_active) begin
            e_seq = bv || pv;
        end else if (!model_waiting()) begin
            e_seq = pv;
            if (bv) m_bits.push_back(bi);
        end else begin
            e_seq = bv;
            if (pv) begin
                e_chk    = 1;
                e_perr   = (pi != model_par());
                err      = e_perr;
                m_active = 0;
            end
        end
`ifdef UART_PAR_ERRCNT_EN
        if (clr) m_cnt = err ? 1 : 0;
        else if (err && m_cnt < A_ERR_MAX) m_cnt++;
`endif
    endtask

    task automatic compare_a(input string tag);
        check({tag, ".busy"},      busy,      m_active);
        check({tag, ".par_ready"}, par_ready, model_waiting());
        check({tag, ".chk_valid"}, chk_valid, e_chk);
        check({tag, ".par_err"},   par_err,   e_perr);
        check({tag, ".seq_err"},   seq_err,   e_seq);
        check({tag, ".err_cnt"},   err_cnt,   m_cnt);
        if (model_waiting()) check({tag, ".par_out"}, par_out, model_par());
    endtask

    task automatic step(input string tag, input logic fs, input logic [1:0] m,
                        input logic bv, input logic bi, input logic pv,
                        input logic pi, input logic clr);
        frame_start = fs; parity_mode = m; bit_valid = bv; bit_in = bi;
        par_valid = pv; par_in = pi; err_clr = clr;
        model_cycle(fs, m, bv, bi, pv, pi, clr);
        @(posedge clk);
        #1;
        compare_a(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 2'b00, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_a(input string tag);
        rst = 1;
        @(posedge clk);
        #1;
        m_active = 0; m_bits.delete(); m_mode = 2'b00; m_cnt = 0;
        e_chk = 0; e_perr = 0; e_seq = 0;
        compare_a(tag);
        check({tag, ".par_out"}, par_out, 1'b0);
        rst = 0;
    endtask

    task automatic send_frame(input string tag, input logic [1:0] m, input int data, input int n);
        step(tag, 1, m, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) step(tag, 0, m, 1, logic'((data >> i) & 1), 0, 0, 0);
    endtask

    task automatic send_par(input string tag, input logic pi, input logic clr);
        step(tag, 0, 2'b00, 0, 0, 1, pi, clr);
    endtask

    logic [4:0] b_data;
    int         sat_exp[5] = '{1, 2, 3, 3, 3};
    logic [A_ERR_W-1:0] cnt_before;

    initial begin
        rst = 1; frame_start = 0; parity_mode = 0; bit_valid = 0; bit_in = 0;
        par_valid = 0; par_in = 0; err_clr = 0;
        b_rst = 1; b_frame_start = 0; b_parity_mode = 0; b_bit_valid = 0; b_bit_in = 0;
        b_par_valid = 0; b_par_in = 0; b_err_clr = 0;

        // ---------------- DUT b: DATA_W=5 ----------------
        @(posedge clk); #1;
        check("b_rst.busy", b_busy, 0);
        check("b_rst.par_ready", b_par_ready, 0);
        check("b_rst.err_cnt", b_err_cnt, 0);
        b_rst = 0;
        b_frame_start = 1; b_parity_mode = 2'b00;
        @(posedge clk); #1;
        b_frame_start = 0;
        b_data = 5'b01011;  // bits 1,1,0,1,0 LSB first
        for (int i = 0; i < 5; i++) begin
            check("b_acc.par_ready", b_par_ready, 0);
            b_bit_valid = 1; b_bit_in = b_data[i];
            @(posedge clk); #1;
        end
        b_bit_valid = 0;
        check("b5.par_ready", b_par_ready, 1);
        check("b5.par_out", b_par_out, 1);
        check("b5.busy", b_busy, 1);
        // Reset wins over a coincident parity strobe: no check is reported.
        b_par_valid = 1; b_par_in = 1; b_rst = 1;
        @(posedge clk); #1;
        b_par_valid = 0; b_rst = 0;
        check("b_rst2.chk_valid", b_chk_valid, 0);
        check("b_rst2.par_err", b_par_err, 0);
        check("b_rst2.busy", b_busy, 0);
        check("b_rst2.par_ready", b_par_ready, 0);
        check("b_rst2.par_out", b_par_out, 0);
        check("b_rst2.seq_err", b_seq_err, 0);

        // ---------------- DUT a: directed ----------------
        reset_a("rst");

        send_frame("even_a5", 2'b00, 'hA5, 8);
        check("even_a5.par_ready_lit", par_ready, 1);
        check("even_a5.par_out_lit", par_out, 0);
        send_par("even_a5_chk", 0, 0);
        check("even_a5.chk_lit", chk_valid, 1);
        check("even_a5.perr_lit", par_err, 0);

        send_frame("odd_01", 2'b01, 'h01, 8);
        check("odd_01.par_out_lit", par_out, 0);
        send_par("odd_01_chk", 1, 0);
        check("odd_01.perr_lit", par_err, 1);
`ifdef UART_PAR_ERRCNT_EN
        check("odd_01.cnt_lit", err_cnt, 1);
`endif
        step("clr", 0, 0, 0, 0, 0, 0, 1);
        check("clr.cnt_lit", err_cnt, 0);

        send_frame("mark_ff", 2'b10, 'hFF, 8);
        check("mark_ff.par_out_lit", par_out, 1);
        send_par("mark_chk", 0, 0);
        check("mark.perr_lit", par_err, 1);
        send_frame("space_ff", 2'b11, 'hFF, 8);
        check("space_ff.par_out_lit", par_out, 0);
        send_par("space_chk", 1, 0);
        check("space.perr_lit", par_err, 1);

        // Saturation of a 2-bit counter, then clear coincident with an error.
        step("sat_clr", 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            send_frame("sat", logic'(k[0]), (k * 37) & 'hFF, 8);
            send_par("sat_chk", ~model_par(), 0);
`ifdef UART_PAR_ERRCNT_EN
            check("sat.cnt_lit", err_cnt, sat_exp[k]);
`else
            check("sat.cnt_lit", err_cnt, 0);
`endif
        end
        send_frame("sat6", 2'b00, 'h3C, 8);
        send_par("sat6_chk", ~model_par(), 1);
`ifdef UART_PAR_ERRCNT_EN
        check("sat6.cnt_lit", err_cnt, 1);
`else
        check("sat6.cnt_lit", err_cnt, 0);
`endif

        // Restart after 3 bits: seq_err, then 8 fresh bits are required.
        send_frame("abort", 2'b00, 'h07, 3);
        step("abort_fs", 1, 2'b01, 0, 0, 0, 0, 0);
        check("abort.seq_lit", seq_err, 1);
        for (int i = 0; i < 7; i++) step("abort_bits", 0, 0, 1, logic'(i[0]), 0, 0, 0);
        check("abort.not_ready_lit", par_ready, 0);
        step("abort_bit8", 0, 0, 1, 1, 0, 0, 0);
        check("abort.ready_lit", par_ready, 1);
        // bit_valid with par_valid while waiting: check done, bit flagged.
        step("bv_pv", 0, 0, 1, 0, 1, model_par(), 0);
        check("bv_pv.chk_lit", chk_valid, 1);
        check("bv_pv.seq_lit", seq_err, 1);

        // Stray par_valid in IDLE.
        cnt_before = err_cnt;
        send_par("stray_pv", 1, 0);
        check("stray_pv.seq_lit", seq_err, 1);
        check("stray_pv.cnt_same", err_cnt, cnt_before);

        // frame_start with bit_valid: bit ignored, no seq_err.
        step("fs_bv", 1, 2'b00, 1, 1, 0, 0, 0);
        check("fs_bv.seq_lit", seq_err, 0);
        for (int i = 0; i < 8; i++) step("fs_bv_bits", 0, 0, 1, 0, 0, 0, 0);
        check("fs_bv.par_out_lit", par_out, 0);

        // Reset while waiting for parity with a parity strobe pending.
        par_valid = 1; par_in = 1;
        reset_a("rst_wait");
        par_valid = 0;

        // ---------------- DUT a: randomized ----------------
        for (int c = 0; c < 4000; c++) begin
            logic fs, bv, bi, pv, pi, clr;
            logic [1:0] m;
            if ($urandom_range(0, 599) == 0) begin
                reset_a("rnd_rst");
                continue;
            end
            fs  = ($urandom_range(0, 24) == 0);
            m   = 2'($urandom_range(0, 3));
            bv  = ($urandom_range(0, 9) < 6);
            bi  = 1'($urandom);
            pv  = model_waiting() ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 39) == 0);
            pi  = 1'($urandom);
            clr = ($urandom_range(0, 39) == 0);
            if (fs) pv = 0;
            step("rnd", fs, m, bv, bi, pv, pi, clr);
        end
        idle("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
